mips_pipe_fwd: RTL and testbench

Five-stage pipelined MIPS-subset core (IF, ID, EX, MEM, WB) with hazard detection, load-use stalling, branch flushing and optional operand forwarding, so programs run correctly without compiler-inserted NOPs. It is the successor to the unprotected pipelined core: the reset vector and the forwarding mode are parameters. Instruction and data memories are external, with combinational reads. A retirement port exposes every register write-back to the bench.

---
 rtl/mips_pipe_fwd.sv | 221 ++++++++++++++++++++++
 tb/tb_mips_pipe_fwd.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_pipe_fwd.sv
// Five-stage MIPS-subset pipeline (IF/ID/EX/MEM/WB) with load-use and branch
// hazard handling; FWD_EN selects EX forwarding or stall-until-writeback.
module mips_pipe_fwd #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          FWD_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] oIMemAddr,
    input  logic [31:0] iIMemData,
    output logic [31:0] oDMemAddr,
    output logic [31:0] oDMemWrData,
    output logic        oDMemWr,
    output logic        oDMemRd,
    input  logic [31:0] iDMemRdData,
    output logic        oWbValid,
    output logic [4:0]  oWbReg,
    output logic [31:0] oWbData
);

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    logic [31:0] pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr, ifid_pc4;

    logic        idex_valid, idex_reg_write, idex_lw, idex_sw, idex_beq, idex_use_imm;
    alu_op_t     idex_alu_op;
    logic [4:0]  idex_rs, idex_rt, idex_dst;
    logic [31:0] idex_pc4, idex_imm, idex_rs_val, idex_rt_val;

    logic        exmem_valid, exmem_reg_write, exmem_lw, exmem_sw;
    logic [4:0]  exmem_dst;
    logic [31:0] exmem_alu, exmem_st_data;

    logic        memwb_valid, memwb_reg_write;
    logic [4:0]  memwb_dst;
    logic [31:0] memwb_data;

    logic [31:0] rf [32];

    logic [5:0]  d_op, d_funct;
    logic [4:0]  d_rs, d_rt, d_rd, d_dst;
    logic        d_rtype, d_lw, d_sw, d_beq, d_addi, d_src, d_use_rt, d_reg_write;
    alu_op_t     d_alu_op;
    logic [31:0] d_imm, d_rs_val, d_rt_val;
    logic        unused_shamt;

    logic        wb_we, hit_ex, hit_mem, hazard, stall, br_taken;
    logic [31:0] fwd_a, fwd_b, op_b, alu_out, br_target;

    assign d_op         = ifid_instr[31:26];
    assign d_rs         = ifid_instr[25:21];
    assign d_rt         = ifid_instr[20:16];
    assign d_rd         = ifid_instr[15:11];
    assign d_funct      = ifid_instr[5:0];
    assign unused_shamt = ^ifid_instr[10:6];
    assign d_imm        = {{16{ifid_instr[15]}}, ifid_instr[15:0]};

    always_comb begin
        d_rtype  = 1'b0;
        d_alu_op = ALU_ADD;
        if (d_op == 6'b000000) begin
            d_rtype = 1'b1;
            case (d_funct)
                6'b100000: d_alu_op = ALU_ADD;
                6'b100010: d_alu_op = ALU_SUB;
                6'b100100: d_alu_op = ALU_AND;
                6'b100101: d_alu_op = ALU_OR;
                6'b101010: d_alu_op = ALU_SLT;
                default:   d_rtype  = 1'b0;
            endcase
        end
    end

    assign d_lw        = (d_op == 6'b100011);
    assign d_sw        = (d_op == 6'b101011);
    assign d_beq       = (d_op == 6'b000100);
    assign d_addi      = (d_op == 6'b001000);
    assign d_src       = d_rtype | d_lw | d_sw | d_beq | d_addi;
    assign d_use_rt    = d_rtype | d_beq | d_sw;
    assign d_dst       = d_rtype ? d_rd : d_rt;
    // Writes to $0 are decoded as non-writing so they never retire or forward.
    assign d_reg_write = (d_rtype | d_lw | d_addi) && (d_dst != 5'd0);

    assign wb_we = memwb_valid && memwb_reg_write;

    always_comb begin
        d_rs_val = rf[d_rs];
        d_rt_val = rf[d_rt];
        if (wb_we && memwb_dst == d_rs) d_rs_val = memwb_data;
        if (wb_we && memwb_dst == d_rt) d_rt_val = memwb_data;
        if (d_rs == 5'd0) d_rs_val = '0;
        if (d_rt == 5'd0) d_rt_val = '0;
    end

    assign hit_ex  = ifid_valid && idex_valid && idex_reg_write &&
                     ((d_src && d_rs == idex_dst) || (d_use_rt && d_rt == idex_dst));
    assign hit_mem = ifid_valid && exmem_valid && exmem_reg_write &&
                     ((d_src && d_rs == exmem_dst) || (d_use_rt && d_rt == exmem_dst));
    assign hazard  = FWD_EN ? (hit_ex && idex_lw) : (hit_ex || hit_mem);
    assign stall   = hazard && !br_taken;

    // Loads are excluded from EX/MEM forwarding; the load-use stall covers them.
    always_comb begin
        fwd_a = idex_rs_val;
        fwd_b = idex_rt_val;
        if (FWD_EN && exmem_valid && exmem_reg_write && !exmem_lw && exmem_dst == idex_rs)
            fwd_a = exmem_alu;
        else if (FWD_EN && wb_we && memwb_dst == idex_rs)
            fwd_a = memwb_data;
        if (FWD_EN && exmem_valid && exmem_reg_write && !exmem_lw && exmem_dst == idex_rt)
            fwd_b = exmem_alu;
        else if (FWD_EN && wb_we && memwb_dst == idex_rt)
            fwd_b = memwb_data;
    end

    always_comb begin
        op_b = idex_use_imm ? idex_imm : fwd_b;
        case (idex_alu_op)
            ALU_SUB: alu_out = fwd_a - op_b;
            ALU_AND: alu_out = fwd_a & op_b;
            ALU_OR:  alu_out = fwd_a | op_b;
            ALU_SLT: alu_out = {31'd0, ($signed(fwd_a) < $signed(op_b))};
            default: alu_out = fwd_a + op_b;
        endcase
    end

    assign br_taken  = idex_valid && idex_beq && (fwd_a == fwd_b);
    assign br_target = idex_pc4 + {idex_imm[29:0], 2'b00};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc              <= RESET_PC;
            ifid_valid      <= 1'b0;
            ifid_instr      <= '0;
            ifid_pc4        <= '0;
            idex_valid      <= 1'b0;
            idex_reg_write  <= 1'b0;
            idex_lw         <= 1'b0;
            idex_sw         <= 1'b0;
            idex_beq        <= 1'b0;
            idex_use_imm    <= 1'b0;
            idex_alu_op     <= ALU_ADD;
            idex_rs         <= '0;
            idex_rt         <= '0;
            idex_dst        <= '0;
            idex_pc4        <= '0;
            idex_imm        <= '0;
            idex_rs_val     <= '0;
            idex_rt_val     <= '0;
            exmem_valid     <= 1'b0;
            exmem_reg_write <= 1'b0;
            exmem_lw        <= 1'b0;
            exmem_sw        <= 1'b0;
            exmem_dst       <= '0;
            exmem_alu       <= '0;
            exmem_st_data   <= '0;
            memwb_valid     <= 1'b0;
            memwb_reg_write <= 1'b0;
            memwb_dst       <= '0;
            memwb_data      <= '0;
        end else begin
            if (br_taken) begin
                pc         <= br_target;
                ifid_valid <= 1'b0;
            end else if (!stall) begin
                pc         <= pc + 32'd4;
                ifid_valid <= 1'b1;
                ifid_instr <= iIMemData;
                ifid_pc4   <= pc + 32'd4;
            end

            idex_valid     <= ifid_valid && !stall && !br_taken;
            idex_reg_write <= d_reg_write;
            idex_lw        <= d_lw;
            idex_sw        <= d_sw;
            idex_beq       <= d_beq;
            idex_use_imm   <= d_lw | d_sw | d_addi;
            idex_alu_op    <= d_alu_op;
            idex_rs        <= d_rs;
            idex_rt        <= d_rt;
            idex_dst       <= d_dst;
            idex_pc4       <= ifid_pc4;
            idex_imm       <= d_imm;
            idex_rs_val    <= d_rs_val;
            idex_rt_val    <= d_rt_val;

            exmem_valid     <= idex_valid;
            exmem_reg_write <= idex_reg_write;
            exmem_lw        <= idex_lw;
            exmem_sw        <= idex_sw;
            exmem_dst       <= idex_dst;
            exmem_alu       <= alu_out;
            exmem_st_data   <= fwd_b;

            memwb_valid     <= exmem_valid;
            memwb_reg_write <= exmem_reg_write;
            memwb_dst       <= exmem_dst;
            memwb_data      <= exmem_lw ? iDMemRdData : exmem_alu;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_we) begin
            rf[memwb_dst] <= memwb_data;
        end
    end

    assign oIMemAddr   = pc;
    assign oDMemAddr   = exmem_alu;
    assign oDMemWrData = exmem_st_data;
    assign oDMemWr     = exmem_valid && exmem_sw && resetn;
    assign oDMemRd     = exmem_valid && exmem_lw;
    assign oWbValid    = wb_we;
    assign oWbReg      = memwb_dst;
    assign oWbData     = memwb_data;

endmodule

// File: tb/tb_mips_pipe_fwd.sv
// Bench for mips_pipe_fwd: one forwarding and one non-forwarding instance run
// the same directed programs; monitors score retirements and stores in order.
module tb_mips_pipe_fwd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn = 1'b0;
    int   cyc = 0;
    int   base = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] imem [64];
    logic [31:0] dmem0 [64];
    logic [31:0] dmem1 [64];
    logic        mem_init = 1'b0;
    logic [31:0] init_val = 32'd0;
    int          wp = 0;

    logic [31:0] ia0, id0, da0, dwd0, drd0, wd0;
    logic        dw0, dr0, wv0;
    logic [4:0]  wr0;
    logic [31:0] ia1, id1, da1, dwd1, drd1, wd1;
    logic        dw1, dr1, wv1;
    logic [4:0]  wr1;

    mips_pipe_fwd #(.RESET_PC(32'h0000_0000), .FWD_EN(1'b1)) dut0 (
        .clk(clk), .resetn(resetn),
        .oIMemAddr(ia0), .iIMemData(id0),
        .oDMemAddr(da0), .oDMemWrData(dwd0), .oDMemWr(dw0), .oDMemRd(dr0),
        .iDMemRdData(drd0),
        .oWbValid(wv0), .oWbReg(wr0), .oWbData(wd0)
    );

    mips_pipe_fwd #(.RESET_PC(32'h0000_0000), .FWD_EN(1'b0)) dut1 (
        .clk(clk), .resetn(resetn),
        .oIMemAddr(ia1), .iIMemData(id1),
        .oDMemAddr(da1), .oDMemWrData(dwd1), .oDMemWr(dw1), .oDMemRd(dr1),
        .iDMemRdData(drd1),
        .oWbValid(wv1), .oWbReg(wr1), .oWbData(wd1)
    );

    assign id0  = (ia0[31:8] == 24'd0) ? imem[ia0[7:2]] : 32'd0;
    assign id1  = (ia1[31:8] == 24'd0) ? imem[ia1[7:2]] : 32'd0;
    assign drd0 = dmem0[da0[7:2]];
    assign drd1 = dmem1[da1[7:2]];

    // Data memories: cleared (word 0x40 preset) while mem_init, else written on strobe.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) begin
                dmem0[i] <= (i == 16) ? init_val : 32'd0;
                dmem1[i] <= (i == 16) ? init_val : 32'd0;
            end
        end else begin
            if (dw0) dmem0[da0[7:2]] <= dwd0;
            if (dw1) dmem1[da1[7:2]] <= dwd1;
        end
    end

    logic [36:0] exp_wb0[$], exp_wb1[$];
    logic [63:0] exp_st0[$], exp_st1[$];
    int          ret0[$], ret1[$];
    logic [36:0] e0, e1;
    logic [63:0] s0, s1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (wv0) begin
                if (exp_wb0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL dut0_wb_extra: got $%0d=%h, required no write-back", wr0, wd0);
                end else begin
                    e0 = exp_wb0.pop_front();
                    check("dut0_wb_reg", 32'(wr0), 32'(e0[36:32]));
                    check("dut0_wb_data", wd0, e0[31:0]);
                    ret0.push_back(cyc);
                end
            end
            if (dw0) begin
                if (exp_st0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL dut0_st_extra: got [%h]=%h, required no store", da0, dwd0);
                end else begin
                    s0 = exp_st0.pop_front();
                    check("dut0_st_addr", da0, s0[63:32]);
                    check("dut0_st_data", dwd0, s0[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            if (wv1) begin
                if (exp_wb1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL dut1_wb_extra: got $%0d=%h, required no write-back", wr1, wd1);
                end else begin
                    e1 = exp_wb1.pop_front();
                    check("dut1_wb_reg", 32'(wr1), 32'(e1[36:32]));
                    check("dut1_wb_data", wd1, e1[31:0]);
                    ret1.push_back(cyc);
                end
            end
            if (dw1) begin
                if (exp_st1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL dut1_st_extra: got [%h]=%h, required no store", da1, dwd1);
                end else begin
                    s1 = exp_st1.pop_front();
                    check("dut1_st_addr", da1, s1[63:32]);
                    check("dut1_st_data", dwd1, s1[31:0]);
                end
            end
        end
    end

    function automatic logic [31:0] i_fmt(input logic [5:0] op, input int rs, input int rt, input int imm);
        logic [4:0]  s, t;
        logic [15:0] m;
        s = rs[4:0]; t = rt[4:0]; m = imm[15:0];
        return {op, s, t, m};
    endfunction

    function automatic logic [31:0] r_fmt(input logic [5:0] funct, input int rd, input int rs, input int rt);
        logic [4:0] d, s, t;
        d = rd[4:0]; s = rs[4:0]; t = rt[4:0];
        return {6'b000000, s, t, d, 5'b00000, funct};
    endfunction

    task automatic emit(input logic [31:0] w);
        imem[wp] = w;
        wp++;
    endtask

    task automatic expect_wb(input int r, input logic [31:0] v);
        logic [4:0] rr;
        rr = r[4:0];
        exp_wb0.push_back({rr, v});
        exp_wb1.push_back({rr, v});
    endtask

    task automatic expect_st(input logic [31:0] a, input logic [31:0] v);
        exp_st0.push_back({a, v});
        exp_st1.push_back({a, v});
    endtask

    task automatic at_cycle(input int k);
        do @(negedge clk); while (cyc < base + k);
    endtask

    task automatic check_reset_state();
        check("rst_dut0_imem_addr", ia0, 32'h0);
        check("rst_dut1_imem_addr", ia1, 32'h0);
        check("rst_dut0_strobes", {25'd0, dw0, dr0, wv0, wr0}, 32'h0);
        check("rst_dut1_strobes", {25'd0, dw1, dr1, wv1, wr1}, 32'h0);
        check("rst_dut0_dmem_addr", da0, 32'h0);
        check("rst_dut0_wdata", dwd0, 32'h0);
        check("rst_dut0_wb_data", wd0, 32'h0);
    endtask

    task automatic start_test(input logic [31:0] word40);
        resetn   = 1'b0;
        mem_init = 1'b1;
        init_val = word40;
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
        wp = 0;
        exp_wb0.delete(); exp_wb1.delete();
        exp_st0.delete(); exp_st1.delete();
        ret0.delete();    ret1.delete();
    endtask

    task automatic do_reset();
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        resetn   = 1'b1;
        base     = cyc;
        at_cycle(0);
        check_reset_state();
    endtask

    task automatic finish_test(input string name);
        check({name, "_dut0_wb_pending"}, exp_wb0.size(), 0);
        check({name, "_dut1_wb_pending"}, exp_wb1.size(), 0);
        check({name, "_dut0_st_pending"}, exp_st0.size(), 0);
        check({name, "_dut1_st_pending"}, exp_st1.size(), 0);
    endtask

    initial begin
        // back-to-back ALU dependencies
        start_test(32'd0);
        emit(i_fmt(6'b001000, 0, 1, 5));
        emit(i_fmt(6'b001000, 1, 2, 3));
        emit(r_fmt(6'b100000, 3, 1, 2));
        emit(r_fmt(6'b100010, 4, 3, 1));
        expect_wb(1, 32'd5); expect_wb(2, 32'd8); expect_wb(3, 32'd13); expect_wb(4, 32'd8);
        do_reset();
        at_cycle(30);
        finish_test("alu");
        if (ret0.size() == 4) check("alu_dut0_span", ret0[3] - ret0[0], 3);
        else check("alu_dut0_count", ret0.size(), 4);
        if (ret1.size() == 4) check("alu_dut1_span", ret1[3] - ret1[0], 9);
        else check("alu_dut1_count", ret1.size(), 4);

        // load-use
        start_test(32'h0000_1234);
        emit(i_fmt(6'b100011, 0, 5, 32'h40));
        emit(r_fmt(6'b100000, 6, 5, 5));
        expect_wb(5, 32'h1234); expect_wb(6, 32'h2468);
        do_reset();
        at_cycle(30);
        finish_test("ldu");
        if (ret0.size() == 2) check("ldu_dut0_gap", ret0[1] - ret0[0], 2);
        else check("ldu_dut0_count", ret0.size(), 2);
        if (ret1.size() == 2) check("ldu_dut1_gap", ret1[1] - ret1[0], 3);
        else check("ldu_dut1_count", ret1.size(), 2);

        // taken branch skips two addi $7
        start_test(32'd0);
        emit(i_fmt(6'b001000, 0, 1, 1));
        emit(i_fmt(6'b000100, 1, 1, 2));
        emit(i_fmt(6'b001000, 0, 7, 1));
        emit(i_fmt(6'b001000, 0, 7, 2));
        emit(i_fmt(6'b001000, 0, 8, 9));
        expect_wb(1, 32'd1); expect_wb(8, 32'd9);
        do_reset();
        at_cycle(3);
        check("br_dut0_pc_c3", ia0, 32'd12);
        at_cycle(4);
        check("br_dut0_target", ia0, 32'd16);
        at_cycle(6);
        check("br_dut1_target", ia1, 32'd16);
        at_cycle(30);
        finish_test("br");

        // store with forwarded negative immediate
        start_test(32'd0);
        emit(i_fmt(6'b001000, 0, 2, -4));
        emit(i_fmt(6'b101011, 0, 2, 8));
        expect_wb(2, 32'hFFFF_FFFC);
        expect_st(32'd8, 32'hFFFF_FFFC);
        do_reset();
        at_cycle(4);
        check("st_dut0_wr_c4", 32'(dw0), 32'd1);
        at_cycle(30);
        finish_test("st");
        check("st_dut0_mem", dmem0[2], 32'hFFFF_FFFC);
        check("st_dut1_mem", dmem1[2], 32'hFFFF_FFFC);

        // cleared register file, $0 write dropped, signed slt
        start_test(32'd0);
        emit(r_fmt(6'b100000, 9, 3, 0));
        emit(i_fmt(6'b001000, 0, 0, 7));
        emit(i_fmt(6'b001000, 0, 1, -1));
        emit(r_fmt(6'b101010, 2, 1, 0));
        expect_wb(9, 32'd0); expect_wb(1, 32'hFFFF_FFFF); expect_wb(2, 32'd1);
        do_reset();
        at_cycle(30);
        finish_test("slt");

        // reset while the sw is in EX, then clean restart
        start_test(32'd0);
        emit(i_fmt(6'b001000, 0, 3, 7));
        emit(i_fmt(6'b101011, 0, 3, 32'h20));
        emit(r_fmt(6'b100000, 4, 3, 3));
        expect_wb(3, 32'd7); expect_wb(4, 32'd14);
        expect_st(32'h20, 32'd7);
        do_reset();
        at_cycle(3);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        base   = cyc;
        at_cycle(0);
        check_reset_state();
        check("rst_mid_dut0_mem", dmem0[8], 32'd0);
        at_cycle(30);
        finish_test("rstmid");
        check("rstmid_dut0_mem", dmem0[8], 32'd7);
        check("rstmid_dut1_mem", dmem1[8], 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
